bcd_entry: RTL and testbench

Push-button decimal entry block for the FPGA board: the input-side counterpart of the 7-segment display driver. Three raw buttons are debounced and edited into a 4-digit BCD value, thousands digit first. On "enter" the BCD value is converted sequentially to a 13-bit binary number, which is presented to the processor with a one-cycle valid strobe. The `digits` and `sel` outputs echo the entry for on-board display.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/bcd_entry.sv | 125 ++++++++++++
 tb/tb_bcd_entry.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the push-button BCD entry block and the 7-segment
// display driver.
//   NUM_W / NUM_MAX : width and saturation value of the binary result
//   N_DIGITS        : number of BCD digits entered
//   ST_*            : entry FSM state encoding
package bcd_pkg;

    localparam int unsigned NUM_W    = 13;
    localparam int unsigned NUM_MAX  = 8191;
    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned ACC_W    = 14;  // holds 9999

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Decimal digit increment with 9 -> 0 wrap.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debouncer.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   raw_i   : raw asynchronous button level
//   level_o : debounced stable level
//   rise_o  : one-cycle pulse on a 0->1 change of the stable level
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             smp;

    assign smp = sync_q[1];

    // The counter tracks consecutive samples that disagree with the stable
    // level; the DEBOUNCE_CYCLES-th such sample flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (smp == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = smp;
            cnt_d   = '0;
            rise_d  = smp;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/bcd_entry.sv
// Push-button 4-digit BCD entry with sequential BCD-to-binary conversion.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   btn_inc   : raw button, increments the selected digit
//   btn_next  : raw button, advances the digit cursor
//   btn_enter : raw button, starts a conversion
//   digits    : BCD digits, [15:12] thousands .. [3:0] units
//   sel       : cursor, 0 = thousands .. 3 = units
//   num       : last converted value (saturated at 8191)
//   num_valid : one-cycle strobe with each new num
//   overflow  : last conversion exceeded 8191
module bcd_entry
    import bcd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_inc,
    input  logic             btn_next,
    input  logic             btn_enter,
    output logic [15:0]      digits,
    output logic [1:0]       sel,
    output logic [NUM_W-1:0] num,
    output logic             num_valid,
    output logic             overflow
);

    logic       inc_ev, next_ev, enter_ev;
    logic [2:0] lvl_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst(rst), .raw_i(btn_inc),   .level_o(lvl_unused[0]), .rise_o(inc_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst(rst), .raw_i(btn_next),  .level_o(lvl_unused[1]), .rise_o(next_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk(clk), .rst(rst), .raw_i(btn_enter), .level_o(lvl_unused[2]), .rise_o(enter_ev)
    );

    logic [1:0]       state_q, state_d;
    logic [15:0]      digits_q, digits_d;
    logic [1:0]       sel_q, sel_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       idx_q, idx_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       cur_digit;

    // Digit 0 is the most significant nibble, so position p lives at (3-p)*4.
    assign cur_digit = digits_q[{~idx_q, 2'b00} +: 4];

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        num_d    = num_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inc_ev)
                    digits_d[{~sel_q, 2'b00} +: 4] = bcd_inc(digits_q[{~sel_q, 2'b00} +: 4]);
                if (next_ev)
                    sel_d = sel_q + 2'd1;
                if (enter_ev) begin
                    state_d = ST_CONV;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_CONV: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (acc_q > ACC_W'(NUM_MAX)) begin
                    num_d = NUM_W'(NUM_MAX);
                    ovf_d = 1'b1;
                end else begin
                    num_d = acc_q[NUM_W-1:0];
                    ovf_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            sel_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign digits    = digits_q;
    assign sel       = sel_q;
    assign num       = num_q;
    assign num_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Randomized self-checking bench for bcd_entry against a digit-array model.
module tb_bcd_entry;
    import bcd_pkg::*;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  b;          // 0 = inc, 1 = next, 2 = enter
    logic [15:0] digits;
    logic [1:0]  sel;
    logic [12:0] num;
    logic        num_valid;
    logic        overflow;

    bcd_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .btn_inc(b[0]), .btn_next(b[1]), .btn_enter(b[2]),
        .digits(digits), .sel(sel), .num(num),
        .num_valid(num_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the entry as an array of decimal digits.
    int md[4];
    int msel;
    int mnum;
    int mov;
    int exp_nv;

    function automatic int model_digits();
        return (md[0] << 12) | (md[1] << 8) | (md[2] << 4) | md[3];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) md[i] = 0;
        msel = 0; mnum = 0; mov = 0;
    endtask

    task automatic model_enter();
        int v;
        v = md[0] * 1000 + md[1] * 100 + md[2] * 10 + md[3];
        mnum = (v > 8191) ? 8191 : v;
        mov  = (v > 8191) ? 1 : 0;
        exp_nv++;
    endtask

    // Strobe monitor: latency from the enter event and one-cycle width.
    int cyc = 0;
    int last_ent = -100;
    int nv_cnt = 0;
    logic prev_nv = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (dut.enter_ev) last_ent = cyc;
        if (num_valid) begin
            nv_cnt++;
            check("nv_latency", cyc - last_ent, 6);
            if (prev_nv) check("nv_width", 2, 1);
        end
        prev_nv = num_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int btn, input int width);
        b[btn] = 1'b1;
        tick(width);
        b[btn] = 1'b0;
        tick(DB + 8);
    endtask

    task automatic check_edit(input string tag);
        check({tag, "_digits"}, int'(digits), model_digits());
        check({tag, "_sel"}, int'(sel), msel);
    endtask

    task automatic do_inc();
        press(0, $urandom_range(DB, DB + 4));
        md[msel] = (md[msel] + 1) % 10;
    endtask

    task automatic do_next();
        press(1, $urandom_range(DB, DB + 4));
        msel = (msel + 1) % 4;
    endtask

    task automatic do_enter(input string tag);
        press(2, DB + 1);
        model_enter();
        check({tag, "_num"}, int'(num), mnum);
        check({tag, "_ovf"}, int'(overflow), mov);
        check({tag, "_nvcnt"}, nv_cnt, exp_nv);
    endtask

    task automatic set_digits(input int d0, input int d1, input int d2, input int d3);
        int t[4];
        t[0] = d0; t[1] = d1; t[2] = d2; t[3] = d3;
        for (int p = 0; p < 4; p++) begin
            while (msel != p) do_next();
            while (md[p] != t[p]) do_inc();
        end
        check_edit("set");
    endtask

    initial begin
        b = '0;
        rst = 1'b0;
        exp_nv = 0;
        model_reset();
        tick(3);
        check("rst_digits", int'(digits), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_num", int'(num), 0);
        check("rst_nv", int'(num_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b1;
        tick(3);

        // Nominal entry and overflow clamp.
        set_digits(1, 2, 3, 4);
        do_enter("nom");
        set_digits(9, 9, 9, 9);
        do_enter("clamp");
        set_digits(0, 0, 4, 2);
        do_enter("small");

        // Wrap-around: 10 increments on thousands, 4 nexts back to 0.
        while (msel != 0) do_next();
        for (int i = 0; i < 10; i++) do_inc();
        check_edit("wrap_inc");
        for (int i = 0; i < 4; i++) do_next();
        check_edit("wrap_next");

        // Debounce: short glitches ignored, long hold counts once.
        for (int i = 0; i < 5; i++) press(0, $urandom_range(1, DB - 1));
        check_edit("glitch");
        press(0, DB);
        md[msel] = (md[msel] + 1) % 10;
        check_edit("min_press");
        press(0, 1000);
        md[msel] = (md[msel] + 1) % 10;
        check_edit("hold");

        // Simultaneous inc and next: increment lands on the old cursor.
        b[0] = 1'b1; b[1] = 1'b1;
        tick(DB + 2);
        b[0] = 1'b0; b[1] = 1'b0;
        tick(DB + 8);
        md[msel] = (md[msel] + 1) % 10;
        msel = (msel + 1) % 4;
        check_edit("both");

        // Busy discard: inc/next events land during CONV.
        b[2] = 1'b1;
        tick(2);
        b[0] = 1'b1; b[1] = 1'b1;
        tick(3);
        b[2] = 1'b0;
        tick(2);
        b[0] = 1'b0; b[1] = 1'b0;
        tick(DB + 10);
        model_enter();
        check_edit("busy");
        check("busy_num", int'(num), mnum);
        check("busy_nvcnt", nv_cnt, exp_nv);

        // Randomized editing and conversions.
        for (int k = 0; k < 60; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4)      do_inc();
            else if (op <= 7) do_next();
            else if (op == 8) do_enter("rnd");
            else              press(0, $urandom_range(1, DB - 1));
            check_edit("rnd");
        end

        // Reset three cycles into a conversion.
        begin
            bit seen;
            seen = 1'b0;
            b[2] = 1'b1;
            for (int k = 0; k < 40 && !seen; k++) begin
                tick(1);
                if (dut.enter_ev) seen = 1'b1;
            end
            if (!seen) check("enter_timeout", 0, 1);
            tick(3);
            rst = 1'b0;
            #1;
            check("mid_digits", int'(digits), 0);
            check("mid_sel", int'(sel), 0);
            check("mid_num", int'(num), 0);
            check("mid_nv", int'(num_valid), 0);
            check("mid_ovf", int'(overflow), 0);
            b[2] = 1'b0;
            tick(3);
            rst = 1'b1;
            tick(DB + 10);
            model_reset();
            check("mid_state", int'(dut.state_q), int'(ST_IDLE));
            check("mid_nvcnt", nv_cnt, exp_nv);
            check_edit("post_rst");
        end

        // Entry still works after the abort.
        set_digits(0, 8, 1, 9);
        do_enter("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
